// File: rtl/rr_mux_8x1.sv
`default_nettype none
// ============================================================================
// Module   : rr_mux_8x1
// Purpose  : Round-robin 8:1 valid/ready merger; tags each word with its lane.
// Revision : 1.0
// ============================================================================
module rr_mux_8x1 #(
    parameter int W = 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [8*W-1:0] in_data,
    input  logic [7:0]     in_valid,
    output logic [7:0]     in_ready,
    output logic [W-1:0]   out_data,
    output logic [2:0]     out_sel,
    output logic           out_valid,
    input  logic           out_ready
);

    localparam int unsigned c_LANES = 8;

    logic [2:0]   r_ptr;
    logic [W-1:0] r_data;
    logic [2:0]   r_sel;
    logic         r_valid;

    logic         w_load;
    logic         w_found;
    logic         w_grant;
    logic [2:0]   w_win;
    logic [2:0]   w_scan_idx;
    logic [W-1:0] w_win_data;

    assign w_load = ~r_valid | out_ready;

    // Scan from the far end back toward ptr so the lane closest to ptr
    // overwrites any later candidate, giving first-match priority.
    always_comb begin
        w_found    = 1'b0;
        w_win      = 3'd0;
        w_scan_idx = 3'd0;
        for (int k = c_LANES - 1; k >= 0; k--) begin
            w_scan_idx = r_ptr + 3'(k);
            if (in_valid[w_scan_idx]) begin
                w_found = 1'b1;
                w_win   = w_scan_idx;
            end
        end
    end

    always_comb begin
        w_win_data = '0;
        for (int k = 0; k < c_LANES; k++) begin
            if (w_win == 3'(k)) begin
                w_win_data = in_data[k*W +: W];
            end
        end
    end

    assign w_grant  = w_load & w_found & ~rst;
    assign in_ready = w_grant ? (8'd1 << w_win) : 8'd0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr   <= 3'd0;
            r_data  <= '0;
            r_sel   <= 3'd0;
            r_valid <= 1'b0;
        end else if (w_grant) begin
            r_data  <= w_win_data;
            r_sel   <= w_win;
            r_valid <= 1'b1;
            r_ptr   <= w_win + 3'd1;
        end else if (w_load) begin
            // Slot drained with nobody waiting: go empty, keep last word/tag.
            r_valid <= 1'b0;
        end
    end

    assign out_data  = r_data;
    assign out_sel   = r_sel;
    assign out_valid = r_valid;

endmodule
`default_nettype wire

// File: tb/tb_rr_mux_8x1.sv
`default_nettype none
// ============================================================================
// Module   : tb_rr_mux_8x1
// Purpose  : Scoreboarded random + directed bench for rr_mux_8x1 (W=4).
// Revision : 1.0
// ============================================================================
module tb_rr_mux_8x1;

    localparam int W = 4;

    logic           clk;
    logic           rst;
    logic [8*W-1:0] in_data;
    logic [7:0]     in_valid;
    logic [7:0]     in_ready;
    logic [W-1:0]   out_data;
    logic [2:0]     out_sel;
    logic           out_valid;
    logic           out_ready;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [2:0]   sel;
        logic [W-1:0] data;
    } item_t;

    item_t q[$];
    int    m_ptr   = 0;
    bit    m_valid = 0;

    rr_mux_8x1 #(.W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: evaluates the arbitration rule from scratch each cycle.
    always @(negedge clk) begin : model
        bit          load;
        int          win;
        logic [7:0]  exp_rdy;
        if (rst) begin
            check("in_ready_in_reset", {24'd0, in_ready}, 32'd0);
            m_ptr   = 0;
            m_valid = 0;
            q.delete();
        end else begin
            check("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
            load = !m_valid || out_ready;
            win  = -1;
            for (int k = 0; k < 8; k++) begin
                if (win < 0 && in_valid[(m_ptr + k) % 8]) win = (m_ptr + k) % 8;
            end
            exp_rdy = 8'd0;
            if (load && win >= 0) exp_rdy[win] = 1'b1;
            check("in_ready", {24'd0, in_ready}, {24'd0, exp_rdy});
            if (exp_rdy != 8'd0) begin
                q.push_back({3'(win), in_data[win*W +: W]});
                m_ptr   = (win + 1) % 8;
                m_valid = 1;
            end else if (load) begin
                m_valid = 0;
            end
        end
    end

    // Monitor: compares whatever word the DUT presents against the queue head.
    always @(negedge clk) begin : monitor
        if (!rst && out_valid) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL monitor_empty: out_valid=1 sel=%0d data=%0h but no word expected", out_sel, out_data);
            end else begin
                check("out_sel", {29'd0, out_sel}, {29'd0, q[0].sel});
                check("out_data", {28'd0, out_data}, {28'd0, q[0].data});
                if (out_ready) void'(q.pop_front());
            end
        end
    end

    task automatic cyc(input logic r, input logic [7:0] v, input logic ordy, input logic [31:0] d);
        rst       = r;
        in_valid  = v;
        out_ready = ordy;
        in_data   = d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; in_valid = 8'hFF; out_ready = 1'b1; in_data = 32'h76543210;

        // Reset with all lanes requesting
        cyc(1'b1, 8'hFF, 1'b1, 32'h76543210);
        cyc(1'b1, 8'hFF, 1'b1, 32'h76543210);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_sel", {29'd0, out_sel}, 32'd0);
        check("rst_out_data", {28'd0, out_data}, 32'd0);
        check("rst_in_ready", {24'd0, in_ready}, 32'd0);

        // Full contention, lane i carries i
        for (int i = 0; i < 16; i++) cyc(1'b0, 8'hFF, 1'b1, 32'h76543210);
        check("contention_last_sel", {29'd0, out_sel}, 32'd7);

        // Single lane 5 with 0xA
        cyc(1'b0, 8'h20, 1'b1, 32'h00A00000);
        check("single_sel", {29'd0, out_sel}, 32'd5);
        check("single_data", {28'd0, out_data}, 32'hA);
        cyc(1'b0, 8'h00, 1'b1, 32'h0);

        // Backpressure: hold lane-2 word, lanes 3 and 6 waiting
        cyc(1'b0, 8'h04, 1'b1, 32'h00000200);
        for (int i = 0; i < 5; i++) cyc(1'b0, 8'h48, 1'b0, 32'h06003000);
        check("bp_held_sel", {29'd0, out_sel}, 32'd2);
        cyc(1'b0, 8'h48, 1'b1, 32'h06003000);
        check("bp_then_lane3", {29'd0, out_sel}, 32'd3);
        cyc(1'b0, 8'h40, 1'b1, 32'h06000000);
        check("bp_then_lane6", {29'd0, out_sel}, 32'd6);

        // Wrap: ptr now 7; lanes 1 and 7 -> 7 then 1, then ptr=2
        cyc(1'b0, 8'h82, 1'b1, 32'h90000050);
        check("wrap_first", {29'd0, out_sel}, 32'd7);
        cyc(1'b0, 8'h82, 1'b1, 32'h90000050);
        check("wrap_second", {29'd0, out_sel}, 32'd1);
        cyc(1'b0, 8'h0D, 1'b1, 32'h0000C30E);
        check("ptr_after_wrap", {29'd0, out_sel}, 32'd2);

        // Reset mid-stream while lane 4 would be granted
        cyc(1'b0, 8'h10, 1'b1, 32'h00040000);
        cyc(1'b1, 8'h10, 1'b1, 32'h00050000);
        check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        cyc(1'b0, 8'hFF, 1'b1, 32'hFEDCBA98);
        check("midrst_first_lane0", {29'd0, out_sel}, 32'd0);

        // Randomized traffic with occasional resets
        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom_range(0, 299) == 0), 8'($urandom) & 8'($urandom),
                ($urandom_range(0, 9) < 7), $urandom);
        end
        cyc(1'b0, 8'h00, 1'b1, 32'h0);
        cyc(1'b0, 8'h00, 1'b1, 32'h0);
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
